// File: rtl/segre_pkg.sv
// =============================================================================
// Module   : segre_pkg
// Brief    : Shared types and constants for the memory arbiter.
// Revision : 1.0 - initial release
// =============================================================================
`default_nettype none

package segre_pkg;

    typedef enum logic [1:0] {
        BYTE = 2'd0,
        HALF = 2'd1,
        WORD = 2'd2
    } memop_data_type_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        RESP  = 2'd2,
        WRITE = 2'd3
    } mem_arb_state_e;

    typedef enum logic [1:0] {
        OWN_IC    = 2'd0,
        OWN_DC_RD = 2'd1,
        OWN_DC_WR = 2'd2
    } mem_arb_owner_e;

    localparam int MEM_ARB_STARVE_MAX = 4;

endpackage

`default_nettype wire

// File: rtl/segre_mem_arb_prio.sv
// =============================================================================
// Module   : segre_mem_arb_prio
// Brief    : Fixed-priority request select with instruction-side anti-starvation.
// Revision : 1.0 - initial release
// =============================================================================
`default_nettype none

module segre_mem_arb_prio
    import segre_pkg::*;
#(
    parameter int STARVE_MAX = MEM_ARB_STARVE_MAX
) (
    input  logic           clk_i,
    input  logic           rsn_i,
    input  logic           sample_i,
    input  logic           ic_rd_req_i,
    input  logic           dc_rd_req_i,
    input  logic           dc_wr_req_i,
    output logic           grant_o,
    output mem_arb_owner_e owner_o
);

    localparam int c_CNT_W = $clog2(STARVE_MAX + 1);

    logic [c_CNT_W-1:0] r_starve_cnt;
    logic               w_starved;

    assign w_starved = (r_starve_cnt == c_CNT_W'(STARVE_MAX));

    // Write ahead of a D$ read keeps store-to-load ordering intact.
    always_comb begin
        grant_o = 1'b0;
        owner_o = OWN_IC;
        if (sample_i) begin
            if (w_starved && ic_rd_req_i) begin
                grant_o = 1'b1;
                owner_o = OWN_IC;
            end else if (dc_wr_req_i) begin
                grant_o = 1'b1;
                owner_o = OWN_DC_WR;
            end else if (dc_rd_req_i) begin
                grant_o = 1'b1;
                owner_o = OWN_DC_RD;
            end else if (ic_rd_req_i) begin
                grant_o = 1'b1;
                owner_o = OWN_IC;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) begin
            r_starve_cnt <= '0;
        end else if (grant_o) begin
            if (owner_o == OWN_IC || !ic_rd_req_i) begin
                r_starve_cnt <= '0;
            end else if (!w_starved) begin
                r_starve_cnt <= r_starve_cnt + 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/segre_mem_arbiter.sv
// =============================================================================
// Module   : segre_mem_arbiter
// Brief    : Main-memory port owner shared by I$ fill, D$ fill and write-back.
//            Optional perf counters enabled by SEGRE_MEM_ARB_PERF_EN.
// Revision : 1.0 - initial release
// =============================================================================
`default_nettype none

module segre_mem_arbiter
    import segre_pkg::*;
#(
    parameter int ADDR_SIZE  = 32,
    parameter int WORD_SIZE  = 32,
    parameter int LANE_SIZE  = 128,
    parameter int STARVE_MAX = MEM_ARB_STARVE_MAX
) (
    input  logic                 clk_i,
    input  logic                 rsn_i,
    input  logic                 ic_rd_req_i,
    input  logic [ADDR_SIZE-1:0] ic_addr_i,
    output logic                 ic_rdy_o,
    output logic [LANE_SIZE-1:0] ic_data_o,
    input  logic                 dc_rd_req_i,
    input  logic [ADDR_SIZE-1:0] dc_rd_addr_i,
    output logic                 dc_rdy_o,
    output logic [LANE_SIZE-1:0] dc_data_o,
    input  logic                 dc_wr_req_i,
    input  logic [ADDR_SIZE-1:0] dc_wr_addr_i,
    input  logic [WORD_SIZE-1:0] dc_wr_data_i,
    input  memop_data_type_e     dc_wr_type_i,
    output logic                 dc_wr_done_o,
    output logic                 mm_rd_o,
    output logic [ADDR_SIZE-1:0] mm_addr_o,
    input  logic                 mm_data_rdy_i,
    input  logic [LANE_SIZE-1:0] mm_rd_data_i,
    output logic                 mm_wr_o,
    output logic [ADDR_SIZE-1:0] mm_wr_addr_o,
    output logic [WORD_SIZE-1:0] mm_wr_data_o,
    output memop_data_type_e     mm_wr_data_type_o,
`ifdef SEGRE_MEM_ARB_PERF_EN
    output logic [31:0]          perf_ic_stall_o,
    output logic [31:0]          perf_dc_stall_o,
    output logic [31:0]          perf_wr_cnt_o,
`endif
    output logic                 busy_o
);

    mem_arb_state_e r_state;
    mem_arb_owner_e r_owner;
    logic           w_grant;
    mem_arb_owner_e w_owner;

    segre_mem_arb_prio #(
        .STARVE_MAX (STARVE_MAX)
    ) u_prio (
        .clk_i       (clk_i),
        .rsn_i       (rsn_i),
        .sample_i    (r_state == IDLE),
        .ic_rd_req_i (ic_rd_req_i),
        .dc_rd_req_i (dc_rd_req_i),
        .dc_wr_req_i (dc_wr_req_i),
        .grant_o     (w_grant),
        .owner_o     (w_owner)
    );

    assign busy_o = (r_state != IDLE);

    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) begin
            r_state           <= IDLE;
            r_owner           <= OWN_IC;
            ic_rdy_o          <= 1'b0;
            ic_data_o         <= '0;
            dc_rdy_o          <= 1'b0;
            dc_data_o         <= '0;
            dc_wr_done_o      <= 1'b0;
            mm_rd_o           <= 1'b0;
            mm_addr_o         <= '0;
            mm_wr_o           <= 1'b0;
            mm_wr_addr_o      <= '0;
            mm_wr_data_o      <= '0;
            mm_wr_data_type_o <= WORD;
        end else begin
            ic_rdy_o     <= 1'b0;
            dc_rdy_o     <= 1'b0;
            dc_wr_done_o <= 1'b0;
            mm_wr_o      <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_grant) begin
                        r_owner <= w_owner;
                        if (w_owner == OWN_DC_WR) begin
                            mm_wr_o           <= 1'b1;
                            dc_wr_done_o      <= 1'b1;
                            mm_wr_addr_o      <= dc_wr_addr_i;
                            mm_wr_data_o      <= dc_wr_data_i;
                            mm_wr_data_type_o <= dc_wr_type_i;
                            r_state           <= WRITE;
                        end else begin
                            mm_rd_o   <= 1'b1;
                            mm_addr_o <= (w_owner == OWN_IC) ? ic_addr_i : dc_rd_addr_i;
                            r_state   <= READ;
                        end
                    end
                end
                READ: begin
                    if (mm_data_rdy_i) begin
                        mm_rd_o <= 1'b0;
                        r_state <= RESP;
                        if (r_owner == OWN_IC) begin
                            ic_data_o <= mm_rd_data_i;
                            ic_rdy_o  <= 1'b1;
                        end else begin
                            dc_data_o <= mm_rd_data_i;
                            dc_rdy_o  <= 1'b1;
                        end
                    end
                end
                RESP:    r_state <= IDLE;
                WRITE:   r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef SEGRE_MEM_ARB_PERF_EN
    logic [31:0] r_ic_stall_cycles;
    logic [31:0] r_dc_stall_cycles;
    logic [31:0] r_wr_count;
    logic        w_ic_owner;
    logic        w_dc_owner;

    assign w_ic_owner = busy_o && (r_owner == OWN_IC);
    assign w_dc_owner = busy_o && (r_owner != OWN_IC);

    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) begin
            r_ic_stall_cycles <= '0;
            r_dc_stall_cycles <= '0;
            r_wr_count        <= '0;
        end else begin
            if (ic_rd_req_i && !w_ic_owner && r_ic_stall_cycles != '1)
                r_ic_stall_cycles <= r_ic_stall_cycles + 32'd1;
            if ((dc_rd_req_i || dc_wr_req_i) && !w_dc_owner && r_dc_stall_cycles != '1)
                r_dc_stall_cycles <= r_dc_stall_cycles + 32'd1;
            if (r_state == WRITE && r_wr_count != '1)
                r_wr_count <= r_wr_count + 32'd1;
        end
    end

    assign perf_ic_stall_o = r_ic_stall_cycles;
    assign perf_dc_stall_o = r_dc_stall_cycles;
    assign perf_wr_cnt_o   = r_wr_count;
`endif

endmodule

`default_nettype wire
